// File: rtl/dlsc_sp605_vtg.sv
// dlsc_sp605_vtg: video timing generator for the SP605 DVI path; counts pixels into
// lines/frames from latched geometry and streams upstream RGB into a registered output bundle.
module dlsc_sp605_vtg #(
   parameter int XBITS = 12,
   parameter int YBITS = 12
) (
   input  logic             px_clk,
   input  logic             px_rst,
   input  logic             cfg_en,
   input  logic [XBITS-1:0] cfg_hdisp,
   input  logic [XBITS-1:0] cfg_hsync_start,
   input  logic [XBITS-1:0] cfg_hsync_end,
   input  logic [XBITS-1:0] cfg_htotal,
   input  logic [YBITS-1:0] cfg_vdisp,
   input  logic [YBITS-1:0] cfg_vsync_start,
   input  logic [YBITS-1:0] cfg_vsync_end,
   input  logic [YBITS-1:0] cfg_vtotal,
   output logic             in_ready,
   input  logic             in_valid,
   input  logic [23:0]      in_data,
   output logic             px_en,
   output logic             px_vsync,
   output logic             px_hsync,
   output logic             px_valid,
   output logic [7:0]       px_r,
   output logic [7:0]       px_g,
   output logic [7:0]       px_b,
   output logic             px_frame_start,
   output logic             underflow
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [XBITS-1:0] x_q, x_d, hdisp_q, hss_q, hse_q, htot_q;
   logic [YBITS-1:0] y_q, y_d, vdisp_q, vss_q, vse_q, vtot_q;
   logic run, active, hs, vs, line_end, frame_end, load;
   always_comb begin
      run       = state_q == RUN;
      active    = x_q < hdisp_q && y_q < vdisp_q;
      hs        = x_q >= hss_q && x_q < hse_q;
      vs        = y_q >= vss_q && y_q < vse_q;
      line_end  = x_q == htot_q;
      frame_end = run && line_end && y_q == vtot_q;
      // geometry is only ever taken between frames so a frame never mixes two configs
      load      = cfg_en && (!run || frame_end);
      state_d   = (!run || frame_end) ? (cfg_en ? RUN : IDLE) : RUN;
      x_d       = (run && !line_end) ? XBITS'(x_q + 1) : '0;
      y_d       = (!run || frame_end) ? '0 : line_end ? YBITS'(y_q + 1) : y_q;
   end
   assign in_ready = run && active;
   always_ff @(posedge px_clk) begin
      if (px_rst) begin
         state_q        <= IDLE;
         x_q            <= '0;
         y_q            <= '0;
         hdisp_q        <= '0;
         hss_q          <= '0;
         hse_q          <= '0;
         htot_q         <= '0;
         vdisp_q        <= '0;
         vss_q          <= '0;
         vse_q          <= '0;
         vtot_q         <= '0;
         px_en          <= 1'b0;
         px_hsync       <= 1'b0;
         px_vsync       <= 1'b0;
         px_valid       <= 1'b0;
         px_frame_start <= 1'b0;
         underflow      <= 1'b0;
         {px_r, px_g, px_b} <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         if (load) begin
            hdisp_q <= cfg_hdisp;
            hss_q   <= cfg_hsync_start;
            hse_q   <= cfg_hsync_end;
            htot_q  <= cfg_htotal;
            vdisp_q <= cfg_vdisp;
            vss_q   <= cfg_vsync_start;
            vse_q   <= cfg_vsync_end;
            vtot_q  <= cfg_vtotal;
         end
         px_en          <= run;
         px_hsync       <= run && hs;
         px_vsync       <= run && vs;
         px_valid       <= in_ready;
         px_frame_start <= run && x_q == '0 && y_q == '0;
         // a missing pixel goes out black with DE held so timing never slips
         underflow      <= in_ready && !in_valid;
         {px_r, px_g, px_b} <= (in_ready && in_valid) ? in_data : '0;
      end
   end
endmodule

// File: tb/tb_dlsc_sp605_vtg.sv
// tb_dlsc_sp605_vtg: directed + randomized bench; the reference model tracks a flat
// pixel index within the frame and derives x/y, region and data with plain arithmetic.
module tb_dlsc_sp605_vtg;
   logic        px_clk = 1'b0;
   logic        px_rst, cfg_en, in_valid, in_ready;
   logic [11:0] cfg_hdisp, cfg_hsync_start, cfg_hsync_end, cfg_htotal;
   logic [11:0] cfg_vdisp, cfg_vsync_start, cfg_vsync_end, cfg_vtotal;
   logic [23:0] in_data;
   logic        px_en, px_vsync, px_hsync, px_valid, px_frame_start, underflow;
   logic [7:0]  px_r, px_g, px_b;
   int checks = 0, failures = 0;
   int m_run = 0, m_t = 0;
   int m_hd = 0, m_hs0 = 0, m_hs1 = 0, m_ht = 0, m_vd = 0, m_vs0 = 0, m_vs1 = 0, m_vt = 0;
   int src = 0;
   logic [23:0] base = '0;

   dlsc_sp605_vtg #(.XBITS(12), .YBITS(12)) dut (
      .px_clk(px_clk), .px_rst(px_rst), .cfg_en(cfg_en),
      .cfg_hdisp(cfg_hdisp), .cfg_hsync_start(cfg_hsync_start),
      .cfg_hsync_end(cfg_hsync_end), .cfg_htotal(cfg_htotal),
      .cfg_vdisp(cfg_vdisp), .cfg_vsync_start(cfg_vsync_start),
      .cfg_vsync_end(cfg_vsync_end), .cfg_vtotal(cfg_vtotal),
      .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
      .px_en(px_en), .px_vsync(px_vsync), .px_hsync(px_hsync), .px_valid(px_valid),
      .px_r(px_r), .px_g(px_g), .px_b(px_b),
      .px_frame_start(px_frame_start), .underflow(underflow)
   );

   always #5 px_clk = ~px_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_geom(input int hd, hs0, hs1, ht, vd, vs0, vs1, vt);
      cfg_hdisp = 12'(hd); cfg_hsync_start = 12'(hs0); cfg_hsync_end = 12'(hs1); cfg_htotal = 12'(ht);
      cfg_vdisp = 12'(vd); cfg_vsync_start = 12'(vs0); cfg_vsync_end = 12'(vs1); cfg_vtotal = 12'(vt);
   endtask

   // One pixel clock: predict from the model, advance the model, compare after the edge.
   task automatic step();
      int x, y;
      logic act, xfer, e_en, e_hs, e_vs, e_de, e_fs, e_uf;
      logic [23:0] e_col;
      x = m_t % (m_ht + 1);
      y = m_t / (m_ht + 1);
      act = m_run != 0 && x < m_hd && y < m_vd;
      chk("in_ready", in_ready, act);
      xfer = act && in_valid;
      e_en = m_run != 0 && !px_rst;
      e_hs = e_en && x >= m_hs0 && x < m_hs1;
      e_vs = e_en && y >= m_vs0 && y < m_vs1;
      e_de = act && !px_rst;
      e_fs = e_en && m_t == 0;
      e_uf = e_de && !in_valid;
      e_col = (xfer && !px_rst) ? in_data : '0;
      if (px_rst) begin
         m_run = 0; m_t = 0;
      end else if (m_run == 0 || m_t == (m_ht + 1) * (m_vt + 1) - 1) begin
         m_t = 0;
         m_run = cfg_en ? 1 : 0;
         if (cfg_en) begin
            m_hd = cfg_hdisp; m_hs0 = cfg_hsync_start; m_hs1 = cfg_hsync_end; m_ht = cfg_htotal;
            m_vd = cfg_vdisp; m_vs0 = cfg_vsync_start; m_vs1 = cfg_vsync_end; m_vt = cfg_vtotal;
         end
      end else m_t++;
      if (xfer && !px_rst) src++;
      @(posedge px_clk);
      #1;
      in_data = base + 24'(src);
      chk("px_en", px_en, e_en);
      chk("px_hsync", px_hsync, e_hs);
      chk("px_vsync", px_vsync, e_vs);
      chk("px_valid", px_valid, e_de);
      chk("px_frame_start", px_frame_start, e_fs);
      chk("underflow", underflow, e_uf);
      chk("px_rgb", {px_r, px_g, px_b}, e_col);
   endtask

   initial begin
      int nv, nh, nvs, nuf, n, dcount, flag;
      logic [23:0] w;
      px_rst = 1'b1; cfg_en = 1'b0; in_valid = 1'b0; in_data = '0;
      set_geom(4, 5, 6, 7, 3, 4, 5, 5);
      @(posedge px_clk);
      #1;
      step(); step();
      chk("rst_en", px_en, 0);
      px_rst = 1'b0;
      step();
      // basic frame and start latency
      cfg_en = 1'b1; in_valid = 1'b1;
      step();
      nv = 0; nh = 0; nvs = 0; dcount = 0;
      for (int i = 0; i < 48; i++) begin
         step();
         if (i == 0) begin
            chk("start_fs", px_frame_start, 1);
            chk("start_en", px_en, 1);
            chk("start_de", px_valid, 1);
            chk("start_data", {px_r, px_g, px_b}, 0);
         end
         nv += int'(px_valid); nh += int'(px_hsync); nvs += int'(px_vsync);
         if (px_valid) begin
            chk("data_seq", {px_r, px_g, px_b}, dcount);
            dcount++;
         end
      end
      chk("valid_cnt", nv, 12);
      chk("hsync_cnt", nh, 6);
      chk("vsync_cnt", nvs, 8);
      step();
      chk("frame_period", px_frame_start, 1);
      // underflow at pixel (2,1)
      nuf = 0; flag = 0; w = '0;
      for (int i = 0; i < 47; i++) begin
         in_valid = !(m_t % (m_ht + 1) == 2 && m_t / (m_ht + 1) == 1);
         w = in_valid ? w : in_data;
         step();
         nuf += int'(underflow);
         if (!in_valid) begin
            chk("uf_pulse", underflow, 1);
            chk("uf_black", {px_r, px_g, px_b}, 0);
            chk("uf_de", px_valid, 1);
            flag = 1;
         end else if (flag == 1) begin
            chk("uf_realign", {px_r, px_g, px_b}, w);
            flag = 0;
         end
      end
      chk("uf_cnt", nuf, 1);
      // random upstream gaps with random data
      base = 24'($urandom);
      in_data = base + 24'(src);
      for (int i = 0; i < 96; i++) begin
         in_valid = $urandom_range(0, 3) != 0;
         step();
      end
      // reconfig mid-frame: old frame keeps 8-cycle lines, next uses 10
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) step();
      cfg_htotal = 12'd9;
      n = 0;
      do begin step(); n++; end while (!px_frame_start && n < 100);
      chk("reconfig_old_fs", px_frame_start, 1);
      cfg_htotal = 12'd7;
      n = 0;
      do begin step(); n++; end while (!px_frame_start && n < 200);
      chk("reconfig_period", n, 60);
      // stop mid-frame at y=2
      n = 0;
      while (m_t != 16 && n < 100) begin step(); n++; end
      chk("stop_reach_y2", m_t, 16);
      cfg_en = 1'b0;
      n = 0;
      do begin step(); n++; end while (px_en && n < 100);
      chk("stop_en_fall", n, 33);
      for (int i = 0; i < 6; i++) step();
      chk("idle_ready", in_ready, 0);
      // reset during active region, then restart
      cfg_en = 1'b1;
      step(); step(); step();
      chk("pre_rst_ready", in_ready, 1);
      px_rst = 1'b1;
      step();
      chk("rst_mid_en", px_en, 0);
      chk("rst_mid_ready", in_ready, 0);
      px_rst = 1'b0;
      step(); step();
      chk("restart_fs", px_frame_start, 1);
      chk("restart_de", px_valid, 1);
      for (int i = 0; i < 50; i++) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dlsc_sp605_vtg.md
# dlsc_sp605_vtg

Video timing generator for the SP605 DVI output path. Counts pixel clocks into lines and frames from run-time geometry registers. Pulls RGB pixels from an upstream ready/valid stream during the active region. Drives the registered `px_en`/`px_vsync`/`px_hsync`/`px_valid`/`px_r`/`px_g`/`px_b` bundle consumed directly by the CH7301C DDR output stage.

## Interface
- `XBITS`, 12, width of horizontal counter and horizontal config fields
- `YBITS`, 12, width of vertical counter and vertical config fields

Ports:
- `px_clk`  in  1  pixel clock; the only clock
- `px_rst`  in  1  synchronous, active-high reset
- `cfg_en`  in  1  run request; level-sensitive
- `cfg_hdisp`, `cfg_hsync_start`, `cfg_hsync_end`, `cfg_htotal`  in  XBITS each  horizontal geometry; `htotal` = last x index
- `cfg_vdisp`, `cfg_vsync_start`, `cfg_vsync_end`, `cfg_vtotal`  in  YBITS each  vertical geometry; `vtotal` = last y index
- `in_ready`  out  1  upstream pixel accept
- `in_valid`  in  1  upstream pixel present
- `in_data`  in  24  pixel {r[23:16], g[15:8], b[7:0]}
- `px_en`  out  1  output stage enable
- `px_vsync`, `px_hsync`  out  1  active-high syncs
- `px_valid`  out  1  data enable (active region)
- `px_r`, `px_g`, `px_b`  out  8 each  pixel colour
- `px_frame_start`  out  1  one-cycle pulse aligned with output pixel (0,0)
- `underflow`  out  1  one-cycle pulse: active pixel had no upstream data

## Operation
- Two states: IDLE, RUN. Reset → IDLE, x=y=0, every output 0.
- **IDLE**
  - `in_ready`=0.
  - On `cfg_en`=1: latch all eight cfg fields into shadow registers, x=y=0, go to RUN.
  - Cfg inputs are ignored while in RUN.
- **RUN**
  - x increments each cycle. At x==htotal: x←0 and y increments. At y==vtotal: y←0.
  - Frame end is x==htotal && y==vtotal. At frame end with `cfg_en`=0: go to IDLE.
  - Otherwise, at frame end, re-latch cfg if `cfg_en`=1; new geometry takes effect at the next (0,0).
  - A frame in progress always completes, even if `cfg_en` drops mid-frame.
- **Decodes** (from the current counters):
  - active = (x < hdisp) && (y < vdisp)
  - hs = hsync_start ≤ x < hsync_end
  - vs = vsync_start ≤ y < vsync_end (whole lines)
- `in_ready` = RUN && active. Combinational from state/counters, never from `in_valid`.
- Pixel transfer: `in_valid` && `in_ready`.
- **Output register** (updated every cycle):
  - px_en ← RUN
  - px_hsync ← RUN&&hs
  - px_vsync ← RUN&&vs
  - px_valid ← RUN&&active
  - px_frame_start ← RUN&&x==0&&y==0
  - {px_r,px_g,px_b} ← transfer ? in_data : 0
  - underflow ← RUN&&active&&!in_valid
- Underflow handling: the output is black for that pixel with `px_valid` still 1. DE is never gapped and timing never stalls. The upstream pixel is not consumed, so the next pixel shifts by one. Re-alignment is upstream's job, using `px_frame_start`.
- Geometry constraint, not checked in hardware: 1 ≤ hdisp ≤ hsync_start < hsync_end ≤ htotal, with the same relation for v. Violations yield defined counter wrap only; no lockup.
- `px_rst` mid-frame: next cycle in IDLE, all outputs 0, any transfer in that cycle discarded.

## Timing
- `cfg_en` sampled high at edge N → RUN with (0,0) in cycle N..N+1.
- `in_ready`=1 during cycle N+1 when hdisp ≥ 1.
- Edge N+2: first registered output, with px_en=1, px_valid=1, px_frame_start=1.
- Latency from counter to outputs is fixed at 1 cycle. Syncs, DE and data stay mutually aligned.
- `in_data` to `px_*` colour latency: 1 cycle.
- Line period = htotal+1 cycles; frame period = (htotal+1)(vtotal+1) cycles.
- After the final frame-end edge: RUN→IDLE. `px_en` falls one cycle later, after the last pixel (htotal,vtotal) has been output.

## Test plan
1. **Basic frame.** Config: hdisp=4, hs 5..6, htotal=7, vdisp=3, vs 4..5, vtotal=5; `in_valid` held 1 with incrementing data. Required:
   - 48-cycle frame, 12 px_valid cycles per frame, in 3 runs of 4
   - px_hsync high 1 cycle per line, at output x=5
   - px_vsync high for lines 4 (8 cycles)
   - data sequence 0..11
2. **Start latency.** `cfg_en` rises at edge N. Required: px_en=px_frame_start=px_valid=1 first at edge N+2, with data = first `in_data`.
3. **Underflow.** Drop `in_valid` at pixel (2,1). Required:
   - underflow pulses once, aligned with output (2,1)
   - colour 0 and px_valid=1 at that pixel
   - the withheld word appears at (3,1)
   - timing is unchanged
4. **Stop mid-frame.** Drop `cfg_en` at y=2. Required: the frame runs to (7,5), then IDLE. px_en goes 0 exactly one cycle after the last pixel, and no further `in_ready`.
5. **Reconfig.** Change htotal to 9 mid-frame with `cfg_en`=1. Required: the current frame keeps 8-cycle lines; the next frame uses 10-cycle lines.
6. **Reset.** Assert `px_rst` during the active region. Required: all outputs 0 the next cycle, and `in_ready`=0. After release with `cfg_en`=1, the frame restarts at (0,0) with the step-2 latency.
